hci_parity_fault_ctrl: RTL and testbench

- Central fault controller for the HCI parity network. Collects the fault_detected outputs of N parity sinks (one per checked HCI link).
- Registers, masks and latches faults per source; records the first-faulting source; keeps a saturating fault-cycle counter; drives a level interrupt until software clears it.
- Sits in the cluster safety/peripheral domain between the parity sinks and the interrupt and status-register fabric.

---
 rtl/hci_parity_fault_ctrl.sv | 135 +++++++++++++
 tb/tb_hci_parity_fault_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hci_parity_fault_ctrl.sv
// Central fault controller for the HCI parity network: registers, masks and latches
// per-sink parity faults, records the first-faulting sink and counts faulty cycles.
module hci_parity_fault_ctrl #(
    parameter int N_SINK = 4,
    parameter int CNT_W  = 8,
    localparam int IDX_W = (N_SINK > 1) ? $clog2(N_SINK) : 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [N_SINK-1:0] fault_i,
    input  logic              enable_i,
    input  logic [N_SINK-1:0] mask_i,
    input  logic              clear_i,
    input  logic              cnt_clear_i,
    output logic              irq_o,
    output logic [N_SINK-1:0] pending_o,
    output logic [IDX_W-1:0]  first_idx_o,
    output logic [CNT_W-1:0]  fault_cnt_o,
    output logic              overflow_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ALERT = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

    state_e              r_state;
    logic                r_irq;
    logic [N_SINK-1:0]   r_fault_q;
    logic [N_SINK-1:0]   r_pending;
    logic [IDX_W-1:0]    r_first_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ovf;

    state_e              w_state_nxt;
    logic [IDX_W-1:0]    w_first_idx_nxt;
    logic [N_SINK-1:0]   w_qual;
    logic                w_inc;
    logic [N_SINK-1:0]   w_pending_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_ovf_nxt;

    // Lowest set bit wins so simultaneous faults resolve deterministically.
    function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_SINK-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = N_SINK - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    assign w_qual        = r_fault_q & ~mask_i & {N_SINK{enable_i}};
    assign w_inc         = |w_qual;
    assign w_pending_nxt = (clear_i ? {N_SINK{1'b0}} : r_pending) | w_qual;

    // Alert FSM next state and first-fault capture.
    always_comb begin
        w_state_nxt     = r_state;
        w_first_idx_nxt = r_first_idx;
        case (r_state)
            ST_IDLE: begin
                if (w_inc) begin
                    w_state_nxt     = ST_ALERT;
                    w_first_idx_nxt = lowest_idx(w_qual);
                end else begin
                    w_state_nxt     = ST_IDLE;
                end
            end
            ST_ALERT: begin
                if (clear_i && w_inc) begin
                    w_first_idx_nxt = lowest_idx(w_qual);
                end else if (clear_i) begin
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_state_nxt     = ST_ALERT;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
            end
        endcase
    end

    // Saturating fault-cycle counter; a clear still counts a coincident fault.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_ovf_nxt = r_ovf;
        if (cnt_clear_i) begin
            w_cnt_nxt = w_inc ? CNT_ONE : {CNT_W{1'b0}};
            w_ovf_nxt = 1'b0;
        end else if (w_inc && (r_cnt == CNT_MAX)) begin
            w_ovf_nxt = 1'b1;
        end else if (w_inc) begin
            w_cnt_nxt = r_cnt + CNT_ONE;
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_irq       <= 1'b0;
            r_fault_q   <= {N_SINK{1'b0}};
            r_pending   <= {N_SINK{1'b0}};
            r_first_idx <= {IDX_W{1'b0}};
            r_cnt       <= {CNT_W{1'b0}};
            r_ovf       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_irq       <= (w_state_nxt == ST_ALERT);
            r_fault_q   <= fault_i;
            r_pending   <= w_pending_nxt;
            r_first_idx <= w_first_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_ovf       <= w_ovf_nxt;
        end
    end

    assign irq_o       = r_irq;
    assign pending_o   = r_pending;
    assign first_idx_o = r_first_idx;
    assign fault_cnt_o = r_cnt;
    assign overflow_o  = r_ovf;

endmodule

// File: tb/tb_hci_parity_fault_ctrl.sv
// Bench for hci_parity_fault_ctrl: directed scenarios plus random traffic, two counter
// widths driven in parallel and checked every cycle against a behavioural model.
module tb_hci_parity_fault_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] fault;
    logic       en;
    logic [3:0] mask;
    logic       clr;
    logic       cclr;

    logic       a_irq, a_ovf, b_irq, b_ovf;
    logic [3:0] a_pend, b_pend;
    logic [1:0] a_first, b_first;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    // Model state
    logic [3:0] m_fq, m_pend;
    bit         m_alert, m_ovf8, m_ovf2;
    int         m_first, m_cnt8, m_cnt2;

    hci_parity_fault_ctrl #(.N_SINK(4), .CNT_W(8)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .enable_i(en), .mask_i(mask),
        .clear_i(clr), .cnt_clear_i(cclr), .irq_o(a_irq), .pending_o(a_pend),
        .first_idx_o(a_first), .fault_cnt_o(a_cnt), .overflow_o(a_ovf)
    );

    hci_parity_fault_ctrl #(.N_SINK(4), .CNT_W(2)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .fault_i(fault), .enable_i(en), .mask_i(mask),
        .clear_i(clr), .cnt_clear_i(cclr), .irq_o(b_irq), .pending_o(b_pend),
        .first_idx_o(b_first), .fault_cnt_o(b_cnt), .overflow_o(b_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] q;
        int low;
        if (!rst_n) begin
            m_fq = 4'b0; m_pend = 4'b0; m_alert = 1'b0; m_first = 0;
            m_cnt8 = 0; m_cnt2 = 0; m_ovf8 = 1'b0; m_ovf2 = 1'b0;
        end else begin
            q   = m_fq & ~mask & (en ? 4'b1111 : 4'b0000);
            low = -1;
            for (int i = 0; i < 4; i++) if (q[i] && low < 0) low = i;
            m_pend = (clr ? 4'b0000 : m_pend) | q;
            if (!m_alert) begin
                if (low >= 0) begin m_alert = 1'b1; m_first = low; end
            end else if (clr) begin
                if (low >= 0) m_first = low;
                else m_alert = 1'b0;
            end
            if (cclr) begin
                m_cnt8 = (low >= 0) ? 1 : 0; m_ovf8 = 1'b0;
                m_cnt2 = (low >= 0) ? 1 : 0; m_ovf2 = 1'b0;
            end else if (low >= 0) begin
                if (m_cnt8 == 255) m_ovf8 = 1'b1; else m_cnt8++;
                if (m_cnt2 == 3) m_ovf2 = 1'b1; else m_cnt2++;
            end
            m_fq = fault;
        end
    endtask

    task automatic compare_all();
        chk("a_irq",   32'(a_irq),   32'(m_alert));
        chk("a_pend",  32'(a_pend),  32'(m_pend));
        chk("a_first", 32'(a_first), 32'(m_first));
        chk("a_cnt",   32'(a_cnt),   32'(m_cnt8));
        chk("a_ovf",   32'(a_ovf),   32'(m_ovf8));
        chk("b_irq",   32'(b_irq),   32'(m_alert));
        chk("b_pend",  32'(b_pend),  32'(m_pend));
        chk("b_first", 32'(b_first), 32'(m_first));
        chk("b_cnt",   32'(b_cnt),   32'(m_cnt2));
        chk("b_ovf",   32'(b_ovf),   32'(m_ovf2));
    endtask

    // One clock: apply inputs, advance model at the edge, check on the falling edge.
    task automatic cyc(input logic [3:0] f, input logic e, input logic [3:0] m,
                       input logic c, input logic cc, input logic r);
        fault = f; en = e; mask = m; clr = c; cclr = cc; rst_n = r;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        fault = 4'b0; en = 1'b1; mask = 4'b0; clr = 1'b0; cclr = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
        cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_irq", 32'(a_irq), 32'd0);
        chk("rst_cnt", 32'(a_cnt), 32'd0);

        // Single fault on sink 2: irq two edges later, held until cleared
        for (int i = 0; i < 3; i++) cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b0100, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("lat_irq_lo", 32'(a_irq), 32'd0);
        cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("lat_irq", 32'(a_irq), 32'd1);
        chk("lat_pend", 32'(a_pend), 32'b0100);
        chk("lat_first", 32'(a_first), 32'd2);
        chk("lat_cnt", 32'(a_cnt), 32'd1);
        for (int i = 0; i < 6; i++) cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("irq_hold", 32'(a_irq), 32'd1);

        // Later faults OR into pending, first index frozen; clear returns to idle
        for (int i = 0; i < 3; i++) cyc(4'b1001, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("or_pend", 32'(a_pend), 32'b1101);
        chk("or_first", 32'(a_first), 32'd2);
        chk("or_cnt", 32'(a_cnt), 32'd4);
        cyc(4'b0, 1'b1, 4'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_irq", 32'(a_irq), 32'd0);
        chk("clr_pend", 32'(a_pend), 32'd0);

        // Mask and global enable
        cyc(4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b1);
        chk("mask_pend", 32'(a_pend), 32'b0010);
        chk("mask_first", 32'(a_first), 32'd1);
        cyc(4'b1111, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b1111, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b0, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("en_pend", 32'(a_pend), 32'b0010);
        chk("en_cnt", 32'(a_cnt), 32'd5);
        cyc(4'b0, 1'b1, 4'b0, 1'b1, 1'b0, 1'b1);

        // Clear coinciding with a new qualified fault starts a new event
        cyc(4'b0001, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b1000, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        cyc(4'b0, 1'b1, 4'b0, 1'b1, 1'b0, 1'b1);
        chk("clrnew_irq", 32'(a_irq), 32'd1);
        chk("clrnew_pend", 32'(a_pend), 32'b1000);
        chk("clrnew_first", 32'(a_first), 32'd3);

        // Saturation on the 2-bit counter, then clear with a coincident fault
        cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cyc(4'b0010, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("sat_b_cnt", 32'(b_cnt), 32'd3);
        chk("sat_b_ovf", 32'(b_ovf), 32'd1);
        chk("sat_a_cnt", 32'(a_cnt), 32'd5);
        cyc(4'b0, 1'b1, 4'b0, 1'b0, 1'b1, 1'b1);
        chk("cclr_b_cnt", 32'(b_cnt), 32'd1);
        chk("cclr_b_ovf", 32'(b_ovf), 32'd0);
        chk("cclr_irq", 32'(a_irq), 32'd1);

        // Reset mid-alert with faults held
        cyc(4'b1111, 1'b1, 4'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_mid_irq", 32'(a_irq), 32'd0);
        chk("rst_mid_pend", 32'(a_pend), 32'd0);
        cyc(4'b1111, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_rel_irq1", 32'(a_irq), 32'd0);
        cyc(4'b1111, 1'b1, 4'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_rel_irq2", 32'(a_irq), 32'd1);
        chk("rst_rel_first", 32'(a_first), 32'd0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] f, m;
            logic e, c, cc, r;
            f  = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'b0;
            e  = ($urandom_range(0, 9) != 0);
            m  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
            c  = ($urandom_range(0, 7) == 0);
            cc = ($urandom_range(0, 999) == 0);
            r  = ($urandom_range(0, 1499) != 0);
            cyc(f, e, m, c, cc, r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
